// File: rtl/scm_mc.sv
// scm_mc: multi-channel send controller.
// Buffers paired metadata+PHV entries in a FIFO and releases them only while the
// send window (start..end) is open. Each entry's channel is taken from the
// metadata; disabled channels and channels past their packet quota have their
// entries popped and dropped. Emitted PHVs carry the UM timestamp sampled at pop.
// Two-flit DMA configuration packets program the per-channel enable/quota
// registers and are forwarded downstream with one cycle of latency.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   in_scm_md/_wr, out_scm_md_alf     metadata ingress, strobe, almost-full
//   in_scm_phv/_wr, out_scm_phv_alf   PHV ingress, strobe, almost-full
//   out_scm_md/_wr, in_scm_md_alf     metadata egress, strobe, downstream almost-full
//   out_scm_phv/_wr, in_scm_phv_alf   PHV egress, strobe, downstream almost-full
//   gac2scm_sent_start/_end           send window open/close pulses
//   cin_scm_data/_wr, cout_scm_ready  configuration ingress
//   cout_scm_data/_wr, cin_scm_ready  configuration egress
//   um2scm_timestamp                  current UM timestamp
module scm_mc #(
  parameter int unsigned MD_W      = 256,
  parameter int unsigned PHV_W     = 1024,
  parameter int unsigned CFG_W     = 134,
  parameter int unsigned TS_W      = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CH_LSB    = 128,
  parameter logic [7:0]  MODULE_ID = 8'd7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MD_W-1:0]  in_scm_md,
  input  logic             in_scm_md_wr,
  output logic             out_scm_md_alf,
  input  logic [PHV_W-1:0] in_scm_phv,
  input  logic             in_scm_phv_wr,
  output logic             out_scm_phv_alf,
  output logic [MD_W-1:0]  out_scm_md,
  output logic             out_scm_md_wr,
  input  logic             in_scm_md_alf,
  output logic [PHV_W-1:0] out_scm_phv,
  output logic             out_scm_phv_wr,
  input  logic             in_scm_phv_alf,
  input  logic             gac2scm_sent_start,
  input  logic             gac2scm_sent_end,
  input  logic [CFG_W-1:0] cin_scm_data,
  input  logic             cin_scm_data_wr,
  output logic             cout_scm_ready,
  output logic [CFG_W-1:0] cout_scm_data,
  output logic             cout_scm_data_wr,
  input  logic             cin_scm_ready,
  input  logic [TS_W-1:0]  um2scm_timestamp
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned CHW = $clog2(NUM_CH);

  localparam logic [CW-1:0] ALF_LVL  = CW'(DEPTH - 2);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [7:0]    NUM_CH_B = 8'(NUM_CH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // ---------------------------------------------------------------- FIFO
  logic [MD_W-1:0]  md_mem  [DEPTH];
  logic [PHV_W-1:0] phv_mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, push, pop;

  logic [0:0]       state_q, state_d;

  logic [MD_W-1:0]  rd_md;
  logic [PHV_W-1:0] rd_phv;
  logic [CHW-1:0]   ch;
  logic             exhausted, emit;

  logic             enable_q [NUM_CH];
  logic [15:0]      quota_q  [NUM_CH];
  logic [15:0]      sent_q   [NUM_CH];

  assign full  = (count_q == FULL_LVL);
  assign empty = (count_q == '0);

  assign out_scm_md_alf  = (count_q >= ALF_LVL);
  assign out_scm_phv_alf = (count_q >= ALF_LVL);

  assign pop  = (state_q == ST_SEND) && !empty && !in_scm_md_alf && !in_scm_phv_alf;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign push = in_scm_md_wr && in_scm_phv_wr && (!full || pop);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      md_mem[wr_ptr_q]  <= in_scm_md;
      phv_mem[wr_ptr_q] <= in_scm_phv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------- window FSM
  always_comb begin
    state_d = state_q;
    if (gac2scm_sent_end)        state_d = ST_IDLE;  // end wins over a coincident start
    else if (gac2scm_sent_start) state_d = ST_SEND;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------- channel gating
  assign rd_md     = md_mem[rd_ptr_q];
  assign rd_phv    = phv_mem[rd_ptr_q];
  assign ch        = rd_md[CH_LSB +: CHW];
  assign exhausted = (quota_q[ch] != 16'd0) && (sent_q[ch] >= quota_q[ch]);
  assign emit      = pop && enable_q[ch] && !exhausted;

  // Low PHV bits are replaced by the timestamp, so they are never read back.
  logic unused_phv_lo;
  assign unused_phv_lo = ^rd_phv[TS_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) sent_q[i] <= '0;
    end else if (gac2scm_sent_start) begin
      for (int i = 0; i < NUM_CH; i++) sent_q[i] <= '0;
    end else if (emit && (sent_q[ch] != 16'hFFFF)) begin
      sent_q[ch] <= sent_q[ch] + 16'd1;
    end
  end

  // ---------------------------------------------------------------- egress
  logic [MD_W-1:0]  out_md_q;
  logic [PHV_W-1:0] out_phv_q;
  logic             out_wr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_md_q  <= '0;
      out_phv_q <= '0;
      out_wr_q  <= 1'b0;
    end else begin
      out_wr_q <= emit;
      if (emit) begin
        out_md_q  <= rd_md;
        out_phv_q <= {rd_phv[PHV_W-1:TS_W], um2scm_timestamp};
      end
    end
  end

  assign out_scm_md     = out_md_q;
  assign out_scm_phv    = out_phv_q;
  assign out_scm_md_wr  = out_wr_q;
  assign out_scm_phv_wr = out_wr_q;

  // ---------------------------------------------------------------- configuration
  logic       cfg_head;
  logic       cfg_we;
  logic [7:0] cfg_reg;

  assign cfg_head = (cin_scm_data[133:132] == 2'b01) || (cin_scm_data[133:132] == 2'b11);
  assign cfg_reg  = cin_scm_data[71:64];
  assign cfg_we   = cin_scm_data_wr && cfg_head &&
                    (cin_scm_data[111:104] == MODULE_ID) &&
                    (cin_scm_data[95:92] == 4'h8) &&
                    (cfg_reg < NUM_CH_B);

  // Registered write: a pop in the same cycle still sees the old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        enable_q[i] <= 1'b1;
        quota_q[i]  <= '0;
      end
    end else if (cfg_we) begin
      enable_q[cfg_reg[CHW-1:0]] <= cin_scm_data[31];
      quota_q[cfg_reg[CHW-1:0]]  <= cin_scm_data[15:0];
    end
  end

  logic [CFG_W-1:0] cout_data_q;
  logic             cout_wr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout_data_q <= '0;
      cout_wr_q   <= 1'b0;
    end else begin
      cout_wr_q <= cin_scm_data_wr;
      if (cin_scm_data_wr) cout_data_q <= cin_scm_data;
    end
  end

  assign cout_scm_data    = cout_data_q;
  assign cout_scm_data_wr = cout_wr_q;
  assign cout_scm_ready   = cin_scm_ready;

endmodule

// File: doc/scm_mc.md
Name: scm_mc

Overview:
Multi-channel send control module, the parametrised successor to the single-stream send controller. It sits between the metadata/PHV producer (gme) and the next pipeline module. It buffers paired metadata+PHV entries in a FIFO and releases them only inside a start/end send window. It enforces a per-channel enable and packet quota, and stamps the UM timestamp into each outgoing PHV. Two-flit configuration packets from DMA program the per-channel registers and are forwarded downstream.

Parameters:
MD_W, 256, metadata width
PHV_W, 1024, PHV width
CFG_W, 134, configuration flit width (fixed format below)
TS_W, 32, timestamp width, written into out_scm_phv[TS_W-1:0]
DEPTH, 16, FIFO entries (power of 2)
NUM_CH, 4, channel count (power of 2, >=2)
CH_LSB, 128, LSB of channel index field in metadata
MODULE_ID, 8'd7, configuration destination id

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_scm_md / in_scm_md_wr / out_scm_md_alf  in/in/out  MD_W/1/1  metadata input, write strobe, almost-full
in_scm_phv / in_scm_phv_wr / out_scm_phv_alf  in/in/out  PHV_W/1/1  PHV input, write strobe, almost-full
out_scm_md / out_scm_md_wr / in_scm_md_alf  out/out/in  MD_W/1/1  metadata output, strobe, downstream almost-full
out_scm_phv / out_scm_phv_wr / in_scm_phv_alf  out/out/in  PHV_W/1/1  PHV output, strobe, downstream almost-full
gac2scm_sent_start / gac2scm_sent_end  in  1 each  send-window start/end pulses
cin_scm_data / cin_scm_data_wr / cout_scm_ready  in/in/out  CFG_W/1/1  configuration input
cout_scm_data / cout_scm_data_wr / cin_scm_ready  out/out/in  CFG_W/1/1  configuration output
um2scm_timestamp  in  TS_W  current UM timestamp

Behaviour:
- Reset (async, rst_n=0): all out_*_wr=0, out data=0, FIFO empty, state IDLE, sent counters=0, enable[ch]=1, quota[ch]=0, cout_scm_data_wr=0.
- Ingress: an entry is pushed only when in_scm_md_wr && in_scm_phv_wr. A lone strobe is ignored. A push while FIFO is full is discarded with no pointer change.
- out_scm_md_alf = out_scm_phv_alf = (count >= DEPTH-2), combinational from count.
- FSM IDLE/SEND. IDLE->SEND on sent_start, which also clears all sent counters. SEND->IDLE on sent_end. Start and end in the same cycle: end wins, state IDLE, counters still cleared.
- Pop condition: state==SEND, FIFO not empty, !in_scm_md_alf, !in_scm_phv_alf. At most one pop per cycle. Push and pop in the same cycle are both allowed, including when full (count unchanged).
- Channel ch = md[CH_LSB +: log2(NUM_CH)]. exhausted = quota[ch]!=0 && sent[ch]>=quota[ch].
- If enable[ch] && !exhausted, the popped entry is emitted the next cycle: out_scm_md_wr=out_scm_phv_wr=1, out_scm_md=md, out_scm_phv={phv[PHV_W-1:TS_W], um2scm_timestamp sampled at pop}, and sent[ch]++ (16-bit, saturating). Otherwise the entry is popped and dropped, with no strobe.
- Output strobes are single-cycle. Data holds its last value when no strobe.
- Config flit format: [133:132] 01=head, 10=tail, 11=single. [111:104] dst id. [95:64] address. [31:0] data.
- Config write: a head or single flit with dst==MODULE_ID, addr[31:28]==4'h8, addr[7:0]<NUM_CH writes register addr[7:0]: enable=data[31], quota=data[15:0]. Otherwise no write.
- Config write vs. pop on the same cycle: the pop uses the pre-write register values.
- Every config flit is forwarded registered, 1-cycle latency, unmodified. cout_scm_ready = cin_scm_ready (combinational).
- Reset mid-window: immediate return to IDLE and all buffered entries are lost.

Test Plan:
1. Reset, then push 3 entries (ch0) while IDLE -> no out wr, count=3. Pulse start -> 3 strobes on consecutive cycles, each phv[31:0] = timestamp at its pop.
2. Config single flit {2'b11,...,id 7, addr 32'h80000001, data 32'h80000002}, then start, then 4 ch1 entries -> exactly 2 emitted, 2 dropped. Config flit appears on cout one cycle later.
3. Config addr 32'h80000002 data 0 (disable ch2), then push ch2 and ch3 entries in SEND -> only the ch3 entry is emitted.
4. Fill 16 entries in IDLE -> alf high from count=14; 17th push discarded. Start with in_scm_md_alf=1 -> no pops until it drops to 0.
5. Start and end in the same cycle -> state IDLE, nothing emitted. Config with dst id 123 -> forwarded, no register change.
6. Assert rst_n=0 mid-burst -> outputs 0 asynchronously, FIFO empty, registers at default.
